keypad_scanner: RTL and testbench



---
 rtl/keypad_defs.sv | 32 +++
 rtl/keypad_frame_scan.sv | 110 +++++++++++
 rtl/keypad_scanner.sv | 133 +++++++++++++
 tb/tb_keypad_scanner.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_defs.sv
// Shared encodings for the keypad scanner: key codes, frame results, FSM states
// and the row/column to key-code map.
package keypad_defs;

  localparam logic [3:0] KEY_NONE  = 4'd0;
  localparam logic [3:0] KEY_ENTER = 4'd10;
  localparam logic [3:0] KEY_ZERO  = 4'd11;
  localparam logic [3:0] KEY_CLEAR = 4'd12;

  localparam logic [1:0] FRAME_NONE   = 2'd0;
  localparam logic [1:0] FRAME_SINGLE = 2'd1;
  localparam logic [1:0] FRAME_MULTI  = 2'd2;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_CLEAR;
        2'd1:    code = KEY_ZERO;
        default: code = KEY_ENTER;
      endcase
    end else begin
      code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_frame_scan.sv
// Row scanner: drives one row low per slot, synchronizes the columns and
// classifies each full 4-row frame as no key, a single key or several keys.
module keypad_frame_scan
  import keypad_defs::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       RESTART,
  output logic [3:0] row_n,
  input  logic [2:0] col_n,
  output logic       frame_done,
  output logic [1:0] frame_kind,
  output logic [3:0] frame_code
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] div_r;
  logic [1:0]    row_r;
  logic [3:0]    row_n_r;
  logic [2:0]    sync1_r, sync2_r;
  logic [1:0]    acc_cnt_r;
  logic [3:0]    acc_code_r;
  logic          frame_done_r;
  logic [1:0]    frame_kind_r;
  logic [3:0]    frame_code_r;

  logic [2:0]    hits_s;
  logic [1:0]    row_hits_s;
  logic [2:0]    sum_s;
  logic [1:0]    tot_s;
  logic [1:0]    col_idx_s;
  logic [3:0]    code_s;
  logic [1:0]    kind_s;
  logic          last_s;

  // Fold this row's sample into the running frame tally (count saturates at 2).
  always_comb begin
    hits_s     = ~sync2_r;
    row_hits_s = {1'b0, hits_s[0]} + {1'b0, hits_s[1]} + {1'b0, hits_s[2]};
    sum_s      = {1'b0, acc_cnt_r} + {1'b0, row_hits_s};
    if (sum_s >= 3'd2) begin
      tot_s = 2'd2;
    end else begin
      tot_s = sum_s[1:0];
    end
    if (hits_s[0]) begin
      col_idx_s = 2'd0;
    end else if (hits_s[1]) begin
      col_idx_s = 2'd1;
    end else begin
      col_idx_s = 2'd2;
    end
    if (row_hits_s == 2'd1) begin
      code_s = key_code(row_r, col_idx_s);
    end else begin
      code_s = acc_code_r;
    end
    case (tot_s)
      2'd0:    kind_s = FRAME_NONE;
      2'd1:    kind_s = FRAME_SINGLE;
      default: kind_s = FRAME_MULTI;
    endcase
    last_s = (div_r == DW'(SCAN_DIV - 1));
  end

  // Row timing, column synchronizer and frame result registers.
  always_ff @(posedge clk) begin
    if (RESTART) begin
      div_r        <= {DW{1'b0}};
      row_r        <= 2'd0;
      row_n_r      <= 4'b1110;
      sync1_r      <= 3'b111;
      sync2_r      <= 3'b111;
      acc_cnt_r    <= 2'd0;
      acc_code_r   <= KEY_NONE;
      frame_done_r <= 1'b0;
      frame_kind_r <= FRAME_NONE;
      frame_code_r <= KEY_NONE;
    end else begin
      sync1_r      <= col_n;
      sync2_r      <= sync1_r;
      frame_done_r <= 1'b0;
      if (last_s) begin
        div_r   <= {DW{1'b0}};
        row_r   <= row_r + 2'd1;
        row_n_r <= ~(4'b0001 << (row_r + 2'd1));
        if (row_r == 2'd3) begin
          frame_done_r <= 1'b1;
          frame_kind_r <= kind_s;
          frame_code_r <= code_s;
          acc_cnt_r    <= 2'd0;
          acc_code_r   <= KEY_NONE;
        end else begin
          acc_cnt_r    <= tot_s;
          acc_code_r   <= code_s;
        end
      end else begin
        div_r <= div_r + DW'(1);
      end
    end
  end

  assign row_n      = row_n_r;
  assign frame_done = frame_done_r;
  assign frame_kind = frame_kind_r;
  assign frame_code = frame_code_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad front end: frame scanner plus press/release debounce FSM that
// holds one code per full press and pulses key_strobe on each new press.
module keypad_scanner
  import keypad_defs::*;
#(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       RESTART,
  output logic [3:0] row_n,
  input  logic [2:0] col_n,
  output logic [3:0] decode,
  output logic       key_strobe
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

  logic          frame_done_s;
  logic [1:0]    frame_kind_s;
  logic [3:0]    frame_code_s;

  logic [1:0]    state_r, state_s;
  logic [3:0]    cand_r, cand_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [CW-1:0] rel_r, rel_s;
  logic [3:0]    decode_r, decode_s;
  logic          strobe_r, strobe_s;

  keypad_frame_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk        (clk),
    .RESTART    (RESTART),
    .row_n      (row_n),
    .col_n      (col_n),
    .frame_done (frame_done_s),
    .frame_kind (frame_kind_s),
    .frame_code (frame_code_s)
  );

  // Debounce FSM; it only moves on frame boundaries.
  always_comb begin
    state_s  = state_r;
    cand_s   = cand_r;
    cnt_s    = cnt_r;
    rel_s    = rel_r;
    decode_s = decode_r;
    strobe_s = 1'b0;
    if (frame_done_s) begin
      case (state_r)
        ST_IDLE: begin
          if (frame_kind_s == FRAME_SINGLE) begin
            cand_s = frame_code_s;
            if (DEBOUNCE_FRAMES == 1) begin
              state_s  = ST_PRESSED;
              decode_s = frame_code_s;
              strobe_s = 1'b1;
              cnt_s    = {CW{1'b0}};
              rel_s    = {CW{1'b0}};
            end else begin
              state_s = ST_DEBOUNCE;
              cnt_s   = CW'(1);
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_DEBOUNCE: begin
          if (frame_kind_s == FRAME_SINGLE && frame_code_s == cand_r) begin
            if (cnt_r + CW'(1) == CW'(DEBOUNCE_FRAMES)) begin
              state_s  = ST_PRESSED;
              decode_s = cand_r;
              strobe_s = 1'b1;
              cnt_s    = {CW{1'b0}};
              rel_s    = {CW{1'b0}};
            end else begin
              cnt_s = cnt_r + CW'(1);
            end
          end else begin
            state_s = ST_IDLE;
            cnt_s   = {CW{1'b0}};
          end
        end
        ST_PRESSED: begin
          // Any key activity, even a different key, keeps the current code.
          if (frame_kind_s == FRAME_NONE) begin
            if (rel_r + CW'(1) == CW'(DEBOUNCE_FRAMES)) begin
              state_s  = ST_IDLE;
              decode_s = KEY_NONE;
              rel_s    = {CW{1'b0}};
            end else begin
              rel_s = rel_r + CW'(1);
            end
          end else begin
            rel_s = {CW{1'b0}};
          end
        end
        default: begin
          state_s  = ST_IDLE;
          decode_s = KEY_NONE;
          cnt_s    = {CW{1'b0}};
          rel_s    = {CW{1'b0}};
        end
      endcase
    end else begin
      strobe_s = 1'b0;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (RESTART) begin
      state_r  <= ST_IDLE;
      cand_r   <= KEY_NONE;
      cnt_r    <= {CW{1'b0}};
      rel_r    <= {CW{1'b0}};
      decode_r <= KEY_NONE;
      strobe_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cand_r   <= cand_s;
      cnt_r    <= cnt_s;
      rel_r    <= rel_s;
      decode_r <= decode_s;
      strobe_r <= strobe_s;
    end
  end

  assign decode     = decode_r;
  assign key_strobe = strobe_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: models the key matrix and checks
// decode/key_strobe against key codes derived from the keypad layout.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       RESTART;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [3:0] decode;
  logic       key_strobe;

  logic [11:0] keys = 12'd0;   // bit r*3+c = key (row r, col c) pressed

  int total = 0;
  int bad   = 0;

  int         strobe_cnt = 0;
  int         viol_cnt   = 0;
  logic [3:0] prev_dec   = 4'd0;
  bit         mon_en     = 1'b0;
  logic [3:0] seen_q[$];

  keypad_scanner dut (
    .clk        (clk),
    .RESTART    (RESTART),
    .row_n      (row_n),
    .col_n      (col_n),
    .decode     (decode),
    .key_strobe (key_strobe)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key shorts its column to its driven-low row.
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!row_n[r] && keys[r*3+c]) col_n[c] = 1'b0;
      end
    end
  end

  // Strobe log and output-protocol watcher.
  always @(negedge clk) begin
    if (mon_en) begin
      if (key_strobe === 1'b1) begin
        strobe_cnt <= strobe_cnt + 1;
        seen_q.push_back(decode);
      end
      if (key_strobe !== (prev_dec == 4'd0 && decode != 4'd0)) viol_cnt <= viol_cnt + 1;
      if (prev_dec != 4'd0 && decode != 4'd0 && decode != prev_dec) viol_cnt <= viol_cnt + 1;
      prev_dec <= decode;
    end
  end

  function automatic logic [3:0] ref_code(input int r, input int c);
    if (r < 3) return 4'(3 * r + c + 1);
    return 4'(12 - c);
  endfunction

  task automatic pos_of(input int k, output int r, output int c);
    if (k <= 9) begin
      r = (k - 1) / 3;
      c = (k - 1) % 3;
    end else begin
      r = 3;
      c = 12 - k;
    end
  endtask

  task automatic wait_decode(input logic [3:0] want, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (decode === want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_keypress(input int r, input int c, input int hold_frames);
    logic [3:0] exp;
    bit ok;
    bit held_ok;
    int s0;
    exp = ref_code(r, c);
    s0  = strobe_cnt;
    keys[r*3+c] = 1'b1;
    wait_decode(exp, 67, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL press_latency key=(%0d,%0d) decode=%0d want=%0d", r, c, decode, exp);
    end
    held_ok = 1'b1;
    for (int i = 0; i < hold_frames * 16; i++) begin
      @(negedge clk);
      if (decode !== exp) held_ok = 1'b0;
    end
    total++;
    if (!held_ok) begin
      bad++;
      $display("FAIL press_hold key=(%0d,%0d) decode=%0d want=%0d", r, c, decode, exp);
    end
    total++;
    if (strobe_cnt - s0 !== 1) begin
      bad++;
      $display("FAIL press_strobes key=(%0d,%0d) got=%0d want=1", r, c, strobe_cnt - s0);
    end
    keys[r*3+c] = 1'b0;
    wait_decode(4'd0, 67, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL release_latency key=(%0d,%0d) decode=%0d want=0", r, c, decode);
    end
    repeat (32) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    bit quiet;
    keys    = 12'd0;
    RESTART = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (row_n !== 4'b1110 || decode !== 4'd0 || key_strobe !== 1'b0) begin
      bad++;
      $display("FAIL reset_values row_n=%b decode=%0d strobe=%b want 1110/0/0", row_n, decode, key_strobe);
    end
    RESTART = 1'b0;
    mon_en  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      total++;
      if (row_n !== exp_row) begin
        bad++;
        $display("FAIL row_walk cycle=%0d row_n=%b want=%b", k, row_n, exp_row);
      end
    end
    quiet = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (decode !== 4'd0 || key_strobe !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin
      bad++;
      $display("FAIL idle_quiet decode=%0d strobe=%b want 0/0", decode, key_strobe);
    end
  endtask

  task automatic test_single();
    test_keypress(1, 1, 20);
  endtask

  task automatic test_sequence();
    int codes[11] = '{10, 11, 1, 2, 10, 1, 3, 10, 1, 4, 10};
    int r, c;
    seen_q.delete();
    for (int i = 0; i < 11; i++) begin
      pos_of(codes[i], r, c);
      test_keypress(r, c, 3);
    end
    total++;
    if (seen_q.size() != 11) begin
      bad++;
      $display("FAIL seq_len got=%0d want=11", seen_q.size());
    end
    for (int i = 0; i < 11 && i < seen_q.size(); i++) begin
      total++;
      if (seen_q[i] !== 4'(codes[i])) begin
        bad++;
        $display("FAIL seq_code idx=%0d got=%0d want=%0d", i, seen_q[i], codes[i]);
      end
    end
  endtask

  task automatic test_bounce();
    int s0;
    bit quiet;
    bit ok;
    s0 = strobe_cnt;
    quiet = 1'b1;
    for (int i = 0; i < 32; i++) begin
      keys[1] = (((i / 5) % 2) == 0);
      @(negedge clk);
      if (decode !== 4'd0) quiet = 1'b0;
    end
    total++;
    if (!quiet || strobe_cnt != s0) begin
      bad++;
      $display("FAIL bounce_quiet decode=%0d strobes=%0d want 0/0", decode, strobe_cnt - s0);
    end
    keys[1] = 1'b1;
    wait_decode(4'd2, 67, ok);
    repeat (2) @(negedge clk);
    total++;
    if (!ok || decode !== 4'd2 || strobe_cnt - s0 != 1) begin
      bad++;
      $display("FAIL bounce_settle decode=%0d strobes=%0d want 2/1", decode, strobe_cnt - s0);
    end
    keys[1] = 1'b0;
    wait_decode(4'd0, 67, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL bounce_release decode=%0d want=0", decode);
    end
    repeat (32) @(negedge clk);
  endtask

  task automatic test_multi();
    int s0;
    bit steady;
    bit ok;
    s0 = strobe_cnt;
    keys[0] = 1'b1;
    keys[8] = 1'b1;
    steady = 1'b1;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (decode !== 4'd0) steady = 1'b0;
    end
    total++;
    if (!steady || strobe_cnt != s0) begin
      bad++;
      $display("FAIL multi_ignored decode=%0d strobes=%0d want 0/0", decode, strobe_cnt - s0);
    end
    keys[0] = 1'b0;
    keys[8] = 1'b0;
    repeat (80) @(negedge clk);
    s0 = strobe_cnt;
    keys[3] = 1'b1;
    wait_decode(4'd4, 67, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL multi_first decode=%0d want=4", decode);
    end
    keys[5] = 1'b1;
    steady = 1'b1;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (decode !== 4'd4) steady = 1'b0;
    end
    total++;
    if (!steady || strobe_cnt - s0 != 1) begin
      bad++;
      $display("FAIL no_rollover decode=%0d strobes=%0d want 4/1", decode, strobe_cnt - s0);
    end
    keys[3] = 1'b0;
    keys[5] = 1'b0;
    wait_decode(4'd0, 67, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL multi_release decode=%0d want=0", decode);
    end
    repeat (32) @(negedge clk);
    test_keypress(1, 2, 3);
  endtask

  task automatic test_restart_held();
    int s0;
    bit ok;
    keys[6] = 1'b1;
    wait_decode(4'd7, 67, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL restart_pre decode=%0d want=7", decode);
    end
    repeat (20) @(negedge clk);
    RESTART = 1'b1;
    @(negedge clk);
    total++;
    if (decode !== 4'd0 || key_strobe !== 1'b0 || row_n !== 4'b1110) begin
      bad++;
      $display("FAIL restart_values decode=%0d strobe=%b row_n=%b want 0/0/1110", decode, key_strobe, row_n);
    end
    RESTART = 1'b0;
    s0 = strobe_cnt;
    wait_decode(4'd7, 67, ok);
    repeat (2) @(negedge clk);
    total++;
    if (!ok || strobe_cnt - s0 != 1) begin
      bad++;
      $display("FAIL restart_redetect decode=%0d strobes=%0d want 7/1", decode, strobe_cnt - s0);
    end
    keys[6] = 1'b0;
    wait_decode(4'd0, 67, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL restart_release decode=%0d want=0", decode);
    end
    repeat (32) @(negedge clk);
  endtask

  task automatic test_random_keys();
    for (int n = 0; n < 6; n++) begin
      test_keypress(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    int'($urandom_range(1, 4)));
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
  endtask

  task automatic test_invariants();
    total++;
    if (viol_cnt !== 0) begin
      bad++;
      $display("FAIL protocol_violations got=%0d want=0", viol_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sequence();
    test_bounce();
    test_multi();
    test_restart_held();
    test_random_keys();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
